// File: rtl/multi_zone_alarm_pkg.sv
// Shared state and command encodings for the multi-zone alarm controller.
// Also holds the active-low one-hot indicator decode used by the top.
package multi_zone_alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED  = 3'd0,
    ST_ARMING    = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY     = 3'd3,
    ST_ALARM     = 3'd4,
    ST_EMERGENCY = 3'd5
  } state_e;

  localparam logic [3:0] CMD_DISARM  = 4'hA;
  localparam logic [3:0] CMD_ARM     = 4'hB;
  localparam logic [3:0] CMD_PANIC   = 4'hC;
  localparam logic [3:0] CMD_SILENCE = 4'hD;

  // Codes 6/7 shift out of the 6-bit field, so every lamp stays dark.
  function automatic logic [5:0] state_onehot_n(input logic [2:0] code);
    return ~(6'b000001 << code);
  endfunction

endpackage

// File: rtl/alarm_delay_timer.sv
// Loadable down-counter shared by the exit, entry and siren delays.
// A load wins over counting; the count holds once it reaches zero.
module alarm_delay_timer #(
  parameter int CNT_W = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: reload, decrement while enabled and nonzero, else hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/multi_zone_alarm_ctrl.sv
// Multi-zone intrusion alarm: zone qualification, WIFI command decode, delay
// sequencing and registered Moore decode of siren, lock, alert and indicators.
module multi_zone_alarm_ctrl
  import multi_zone_alarm_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int CMD_W     = 4,
  parameter int EXIT_DLY  = 50_000_000,
  parameter int ENTRY_DLY = 100_000_000,
  parameter int SIREN_DLY = 500_000_000,
  parameter int CNT_W     = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_ZONES-1:0] zone_trip,
  input  logic [NUM_ZONES-1:0] zone_bypass,
  input  logic [NUM_ZONES-1:0] zone_instant,
  input  logic                 hub_trip,
  input  logic [CMD_W-1:0]     cmd,
  input  logic                 cmd_valid,
  output logic                 wifi_out,
  output logic                 siren,
  output logic                 lock,
  output logic [5:0]           state_n,
  output logic [2:0]           message,
  output logic [NUM_ZONES-1:0] trip_log
);

  localparam logic [CMD_W-1:0] DISARM_CODE  = CMD_W'(CMD_DISARM);
  localparam logic [CMD_W-1:0] ARM_CODE     = CMD_W'(CMD_ARM);
  localparam logic [CMD_W-1:0] PANIC_CODE   = CMD_W'(CMD_PANIC);
  localparam logic [CMD_W-1:0] SILENCE_CODE = CMD_W'(CMD_SILENCE);

  state_e               state_r;
  state_e               nxt_state_s;
  logic                 mute_r;
  logic                 mute_set_s;
  logic                 mute_clr_s;
  logic                 log_clr_s;
  logic                 tmr_load_s;
  logic [CNT_W-1:0]     tmr_val_s;
  logic                 tmr_en_s;
  logic                 tmr_zero_s;
  logic [NUM_ZONES-1:0] act_s;
  logic                 inst_trip_s;
  logic                 dly_trip_s;
  logic                 is_disarm_s;
  logic                 is_arm_s;
  logic                 is_panic_s;
  logic                 is_silence_s;
  logic                 log_en_s;

  assign act_s        = zone_trip & ~zone_bypass;
  assign inst_trip_s  = |(act_s & zone_instant);
  assign dly_trip_s   = |(act_s & ~zone_instant);
  assign is_disarm_s  = cmd_valid && (cmd == DISARM_CODE);
  assign is_arm_s     = cmd_valid && (cmd == ARM_CODE);
  assign is_panic_s   = cmd_valid && (cmd == PANIC_CODE);
  assign is_silence_s = cmd_valid && (cmd == SILENCE_CODE);
  assign tmr_en_s     = (state_r == ST_ARMING) || (state_r == ST_ENTRY) ||
                        (state_r == ST_ALARM);
  assign log_en_s     = (state_r == ST_ARMED) || (state_r == ST_ENTRY) ||
                        (state_r == ST_ALARM) || (state_r == ST_EMERGENCY);

  alarm_delay_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .en       (tmr_en_s),
    .zero     (tmr_zero_s)
  );

  // Next-state and side-effect selection; global commands outrank state rules.
  always_comb begin
    nxt_state_s = state_r;
    tmr_load_s  = 1'b0;
    tmr_val_s   = '0;
    mute_set_s  = 1'b0;
    mute_clr_s  = 1'b0;
    log_clr_s   = 1'b0;
    if (is_panic_s) begin
      nxt_state_s = ST_EMERGENCY;
    end else if (is_disarm_s) begin
      nxt_state_s = ST_DISARMED;
    end else begin
      case (state_r)
        ST_DISARMED: begin
          if (is_arm_s) begin
            nxt_state_s = ST_ARMING;
            tmr_load_s  = 1'b1;
            tmr_val_s   = CNT_W'(EXIT_DLY - 1);
            log_clr_s   = 1'b1;
          end else begin
            nxt_state_s = ST_DISARMED;
          end
        end
        ST_ARMING: begin
          if (tmr_zero_s) begin
            nxt_state_s = ST_ARMED;
          end else begin
            nxt_state_s = ST_ARMING;
          end
        end
        ST_ARMED: begin
          if (hub_trip) begin
            nxt_state_s = ST_EMERGENCY;
          end else if (inst_trip_s) begin
            nxt_state_s = ST_ALARM;
            tmr_load_s  = 1'b1;
            tmr_val_s   = CNT_W'(SIREN_DLY - 1);
            mute_clr_s  = 1'b1;
          end else if (dly_trip_s) begin
            nxt_state_s = ST_ENTRY;
            tmr_load_s  = 1'b1;
            tmr_val_s   = CNT_W'(ENTRY_DLY - 1);
          end else begin
            nxt_state_s = ST_ARMED;
          end
        end
        ST_ENTRY: begin
          if (hub_trip) begin
            nxt_state_s = ST_EMERGENCY;
          end else if (inst_trip_s || tmr_zero_s) begin
            nxt_state_s = ST_ALARM;
            tmr_load_s  = 1'b1;
            tmr_val_s   = CNT_W'(SIREN_DLY - 1);
            mute_clr_s  = 1'b1;
          end else begin
            nxt_state_s = ST_ENTRY;
          end
        end
        ST_ALARM: begin
          if (is_arm_s) begin
            nxt_state_s = ST_ARMED;
          end else if (hub_trip) begin
            nxt_state_s = ST_EMERGENCY;
          end else if (is_silence_s || tmr_zero_s) begin
            nxt_state_s = ST_ALARM;
            mute_set_s  = 1'b1;
          end else begin
            nxt_state_s = ST_ALARM;
          end
        end
        ST_EMERGENCY: begin
          if (is_arm_s) begin
            nxt_state_s = ST_ARMED;
          end else begin
            nxt_state_s = ST_EMERGENCY;
          end
        end
        default: nxt_state_s = ST_DISARMED;
      endcase
    end
  end

  // State, mute flag, trip log and the outputs decoded from the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= ST_DISARMED;
      mute_r   <= 1'b0;
      trip_log <= '0;
      wifi_out <= 1'b0;
      siren    <= 1'b0;
      lock     <= 1'b0;
      message  <= 3'd0;
      state_n  <= 6'b111110;
    end else begin
      state_r <= nxt_state_s;
      if (mute_clr_s) begin
        mute_r <= 1'b0;
      end else if (mute_set_s) begin
        mute_r <= 1'b1;
      end else begin
        mute_r <= mute_r;
      end
      if (log_clr_s) begin
        trip_log <= '0;
      end else if (log_en_s) begin
        trip_log <= trip_log | act_s;
      end else begin
        trip_log <= trip_log;
      end
      message <= state_r;
      state_n <= state_onehot_n(state_r);
      case (state_r)
        ST_ALARM: begin
          wifi_out <= 1'b1;
          siren    <= ~mute_r;
          lock     <= 1'b0;
        end
        ST_EMERGENCY: begin
          wifi_out <= 1'b1;
          siren    <= 1'b1;
          lock     <= 1'b1;
        end
        default: begin
          wifi_out <= 1'b0;
          siren    <= 1'b0;
          lock     <= 1'b0;
        end
      endcase
    end
  end

endmodule
